multi_uart_tx: RTL and testbench
================================

// Module: multi_uart_tx
// PURPOSE
//  Parametrised N-channel serial transmitter peripheral on the 6809 bus.
//  Generalises the fixed TXD/TXD2 outputs: per-channel TX FIFO, shared baud prescaler,
//  status/control registers, and a maskable TX-empty interrupt merged onto IRQ.
//  Sits behind the CPLD address decoder, which supplies SEL for the I/O page.
// PARAMETERS
//  CHANNELS   2   number of TX channels (1..8)
//  DEPTH      4   FIFO entries per channel, power of two (2..16)
//  DIVISOR    16  E cycles per serial bit (>=2)
//  STOP_BITS  1   stop bits per frame (1 or 2)
//  localparam RSW = clog2(2*CHANNELS), register-select width
// PORTS
//  E      in   1         bus clock; all state changes on rising edge
//  RESET  in   1         synchronous, active-high reset
//  SEL    in   1         chip select from the address decoder
//  RW     in   1         1 = read, 0 = write (6809 convention)
//  RS     in   RSW       register select (ADDR low bits)
//  DIN    in   8         write data
//  DOUT   out  8         read data (combinational)
//  IRQ    out  1         interrupt, active-low (CPU pin polarity)
//  TXD    out  CHANNELS  serial outputs, idle high, registered
// BEHAVIOUR
//  Register map, channel c: RS=2c data (W: push FIFO; R: 0x00),
//   RS=2c+1 status/ctrl. Status R bits: [0] FIFO not full, [1] FIFO empty and tx idle,
//   [2] IE, [3] OVR sticky, [7:4] 0. Ctrl W: bit2 -> IE, bit3=1 clears OVR.
//   RS beyond 2*CHANNELS-1: reads 0x00, writes ignored.
//  Bus access: one write per E cycle where SEL=1 and RW=0; no read side effects.
//   DOUT = selected register when SEL=1 and RW=1, else 0x00.
//  Reset: FIFOs empty, all channels IDLE, TXD all 1, IE=0, OVR=0, prescaler=0,
//   IRQ=1. Reset mid-frame aborts the frame; TXD=1 from the next edge.
//  Prescaler: free-running count 0..DIVISOR-1, shared; tick when count==DIVISOR-1.
//  Per-channel FSM, advancing only on tick:
//   IDLE : FIFO non-empty -> pop head, TXD<=0, -> START
//   START: TXD<=bit0, bitcnt=0 -> DATA
//   DATA : bitcnt<7 -> TXD<=next bit (LSB first); bitcnt==7 -> TXD<=1 -> STOP
//   STOP : after STOP_BITS ticks high -> IDLE; if FIFO non-empty on that tick,
//          pop and TXD<=0 -> START (back-to-back, no extra idle bit)
//   Every bit lasts exactly DIVISOR cycles; start latency after push is 1..DIVISOR cycles.
//  FIFO: push on data write if not full; full write is dropped and sets OVR.
//   Fullness is evaluated before a same-cycle pop (full + pop + push -> dropped, OVR=1).
//   Pointers wrap modulo DEPTH; count width clog2(DEPTH)+1.
//  IRQ = ~|(IE[c] & empty_idle[c]) over channels, registered (1-cycle lag).
//  Channels are fully independent except for the shared prescaler.
// TESTING (CHANNELS=2, DEPTH=4, DIVISOR=4, STOP_BITS=1)
//  1 Reset: RESET=1 two cycles -> TXD=2'b11, IRQ=1, status ch0 reads 0x03.
//  2 Write 0x55 to RS=0 -> TXD[0] shows 0,1,0,1,0,1,0,1,0,1, 4 cycles each, then idle.
//     TXD[1] stays 1 throughout.
//  3 Write 0xA1,0xB2 back-to-back to ch1 -> two frames, second start bit right after
//     the first stop bit; total 80 cycles of frame time.
//  4 Five writes to ch0 with tx stalled in START -> 5th dropped, status bit3=1;
//     write 0x08 to RS=1 -> bit3 clears.
//  5 Write 0x04 to RS=3 (IE ch1) while ch1 empty -> IRQ=0 next cycle;
//     push ch1 -> IRQ=1 until frame done, then 0 again.
//  6 RESET asserted mid-DATA on ch0 -> TXD[0]=1 next edge, FIFO empty, status 0x03.

Source files
------------

// File: rtl/multi_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : multi_uart_tx
// Description : N-channel 8N1/8N2 serial transmitter on the 6809 bus, with
//               per-channel TX FIFO, shared baud prescaler and TX-empty IRQ.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_uart_tx #(
    parameter int CHANNELS  = 2,
    parameter int DEPTH     = 4,
    parameter int DIVISOR   = 16,
    parameter int STOP_BITS = 1,
    localparam int RSW      = $clog2(2 * CHANNELS)
) (
    input  logic                E,
    input  logic                RESET,
    input  logic                SEL,
    input  logic                RW,
    input  logic [RSW-1:0]      RS,
    input  logic [7:0]          DIN,
    output logic [7:0]          DOUT,
    output logic                IRQ,
    output logic [CHANNELS-1:0] TXD
);

    localparam int   AW        = $clog2(DEPTH);
    localparam int   CW        = $clog2(DEPTH) + 1;
    localparam int   PW        = $clog2(DIVISOR);
    localparam logic LAST_STOP = (STOP_BITS == 2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    logic [PW-1:0]       presc_q, presc_d;
    logic                tick;
    logic                irq_q, irq_d;
    logic [CHANNELS-1:0] empty_idle, not_full, ie, ovr;
    logic [7:0]          dout;

    always_comb begin
        tick    = (presc_q == PW'(DIVISOR - 1));
        presc_d = tick ? '0 : presc_q + PW'(1);
        irq_d   = ~|(ie & empty_idle);
    end

    always_ff @(posedge E) begin
        if (RESET) begin
            presc_q <= '0;
            irq_q   <= 1'b1;
        end else begin
            presc_q <= presc_d;
            irq_q   <= irq_d;
        end
    end

    assign IRQ = irq_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        localparam logic [RSW-1:0] DATA_RS = RSW'(2 * c);
        localparam logic [RSW-1:0] CTRL_RS = RSW'(2 * c + 1);

        logic [7:0]    mem_q [DEPTH];
        logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
        logic [CW-1:0] count_q, count_d;
        state_e        state_q, state_d;
        logic [7:0]    shift_q, shift_d;
        logic [2:0]    bitcnt_q, bitcnt_d;
        logic          stop_q, stop_d;
        logic          txd_q, txd_d;
        logic          ie_q, ie_d, ovr_q, ovr_d;
        logic          wr_data, wr_ctrl, full, empty, push, pop;

        always_comb begin
            wr_data  = SEL && !RW && (RS == DATA_RS);
            wr_ctrl  = SEL && !RW && (RS == CTRL_RS);
            full     = (count_q == CW'(DEPTH));
            empty    = (count_q == '0);
            // Fullness is judged before any same-cycle pop.
            push     = wr_data && !full;
            pop      = 1'b0;
            state_d  = state_q;
            shift_d  = shift_q;
            bitcnt_d = bitcnt_q;
            stop_d   = stop_q;
            txd_d    = txd_q;

            if (tick) begin
                case (state_q)
                    ST_IDLE: begin
                        if (!empty) begin
                            pop     = 1'b1;
                            txd_d   = 1'b0;
                            state_d = ST_START;
                        end
                    end
                    ST_START: begin
                        txd_d    = shift_q[0];
                        bitcnt_d = 3'd0;
                        state_d  = ST_DATA;
                    end
                    ST_DATA: begin
                        if (bitcnt_q != 3'd7) begin
                            bitcnt_d = bitcnt_q + 3'd1;
                            txd_d    = shift_q[bitcnt_q + 3'd1];
                        end else begin
                            txd_d   = 1'b1;
                            stop_d  = 1'b0;
                            state_d = ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        if (stop_q == LAST_STOP) begin
                            if (!empty) begin
                                pop     = 1'b1;
                                txd_d   = 1'b0;
                                state_d = ST_START;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            stop_d = 1'b1;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end

            if (pop) shift_d = mem_q[rd_ptr_q];
            wr_ptr_d = wr_ptr_q + AW'(push);
            rd_ptr_d = rd_ptr_q + AW'(pop);
            count_d  = count_q + CW'(push) - CW'(pop);

            ie_d  = wr_ctrl ? DIN[2] : ie_q;
            ovr_d = ovr_q;
            if (wr_data && full)
                ovr_d = 1'b1;
            else if (wr_ctrl && DIN[3])
                ovr_d = 1'b0;
        end

        always_ff @(posedge E) begin
            if (push) mem_q[wr_ptr_q] <= DIN;
        end

        always_ff @(posedge E) begin
            if (RESET) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                state_q  <= ST_IDLE;
                shift_q  <= '0;
                bitcnt_q <= '0;
                stop_q   <= 1'b0;
                txd_q    <= 1'b1;
                ie_q     <= 1'b0;
                ovr_q    <= 1'b0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                count_q  <= count_d;
                state_q  <= state_d;
                shift_q  <= shift_d;
                bitcnt_q <= bitcnt_d;
                stop_q   <= stop_d;
                txd_q    <= txd_d;
                ie_q     <= ie_d;
                ovr_q    <= ovr_d;
            end
        end

        assign empty_idle[c] = empty && (state_q == ST_IDLE);
        assign not_full[c]   = !full;
        assign ie[c]         = ie_q;
        assign ovr[c]        = ovr_q;
        assign TXD[c]        = txd_q;
    end

    // Only status registers return data; data registers and unmapped RS read 0.
    always_comb begin
        dout = 8'h00;
        if (SEL && RW) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (RS == RSW'(2 * c + 1))
                    dout = {4'b0000, ovr[c], ie[c], empty_idle[c], not_full[c]};
            end
        end
    end

    assign DOUT = dout;

endmodule
`default_nettype wire

// File: tb/tb_multi_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_uart_tx
// Description : Randomised bench for multi_uart_tx against a bit-queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_uart_tx;

    localparam int CH    = 2;
    localparam int DEPTH = 4;
    localparam int DIV   = 4;
    localparam int STOPB = 1;
    localparam int RSW   = 2;

    logic           clk = 1'b0;
    logic           rst, sel, rw;
    logic [RSW-1:0] rs;
    logic [7:0]     din, dout;
    logic           irq;
    logic [CH-1:0]  txd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_uart_tx #(
        .CHANNELS (CH),
        .DEPTH    (DEPTH),
        .DIVISOR  (DIV),
        .STOP_BITS(STOPB)
    ) dut (
        .E    (clk),
        .RESET(rst),
        .SEL  (sel),
        .RW   (rw),
        .RS   (rs),
        .DIN  (din),
        .DOUT (dout),
        .IRQ  (irq),
        .TXD  (txd)
    );

    // Model: each channel holds a byte queue and a queue of line levels still
    // to be shown, one level per baud tick.
    logic [7:0] mfifo  [CH][$];
    logic       mframe [CH][$];
    logic       mline  [CH];
    logic       mbusy  [CH];
    logic       mie    [CH];
    logic       movr   [CH];
    logic       mirq;
    int         mphase;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_status(input int c);
        logic ei;
        logic nf;
        ei = (mfifo[c].size() == 0) && !mbusy[c];
        nf = (mfifo[c].size() < DEPTH);
        return {4'b0000, movr[c], mie[c], ei, nf};
    endfunction

    function automatic logic [7:0] exp_dout();
        int a;
        a = int'(rs);
        if (sel && rw && (a % 2 == 1) && (a < 2 * CH))
            return exp_status(a / 2);
        return 8'h00;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            mfifo[c].delete();
            mframe[c].delete();
            mline[c] = 1'b1;
            mbusy[c] = 1'b0;
            mie[c]   = 1'b0;
            movr[c]  = 1'b0;
        end
        mirq   = 1'b1;
        mphase = 0;
    endtask

    task automatic model_step();
        logic       any_irq;
        logic       tick;
        logic       full_before;
        logic [7:0] b;
        if (rst) begin
            model_reset();
            return;
        end
        any_irq = 1'b0;
        for (int c = 0; c < CH; c++)
            if (mie[c] && mfifo[c].size() == 0 && !mbusy[c]) any_irq = 1'b1;
        tick = (mphase == DIV - 1);
        for (int c = 0; c < CH; c++) begin
            full_before = (mfifo[c].size() == DEPTH);
            if (tick) begin
                if (mframe[c].size() != 0) begin
                    mline[c] = mframe[c].pop_front();
                end else if (mfifo[c].size() != 0) begin
                    b = mfifo[c].pop_front();
                    for (int i = 0; i < 8; i++) mframe[c].push_back(b[i]);
                    for (int s = 0; s < STOPB; s++) mframe[c].push_back(1'b1);
                    mline[c] = 1'b0;
                    mbusy[c] = 1'b1;
                end else begin
                    mbusy[c] = 1'b0;
                    mline[c] = 1'b1;
                end
            end
            if (sel && !rw) begin
                if (int'(rs) == 2 * c) begin
                    if (full_before) movr[c] = 1'b1;
                    else mfifo[c].push_back(din);
                end
                if (int'(rs) == 2 * c + 1) begin
                    mie[c] = din[2];
                    if (din[3]) movr[c] = 1'b0;
                end
            end
        end
        mphase = tick ? 0 : mphase + 1;
        mirq   = !any_irq;
    endtask

    task automatic cycle(input logic r, input logic s, input logic w,
                         input logic [RSW-1:0] a, input logic [7:0] d);
        @(negedge clk);
        rst = r; sel = s; rw = w; rs = a; din = d;
        #1 check_eq("dout", dout, exp_dout());
        @(posedge clk);
        model_step();
        #1;
        for (int c = 0; c < CH; c++)
            check_eq($sformatf("txd%0d", c), {7'b0, txd[c]}, {7'b0, mline[c]});
        check_eq("irq", {7'b0, irq}, {7'b0, mirq});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b1, '0, 8'h00);
    endtask

    task automatic wr(input logic [RSW-1:0] a, input logic [7:0] d);
        cycle(1'b0, 1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [RSW-1:0] a);
        cycle(1'b0, 1'b1, 1'b1, a, 8'h00);
    endtask

    int          wr_pct;
    logic [1:0]  r_rs;

    initial begin
        rst = 1'b1; sel = 1'b0; rw = 1'b1; rs = '0; din = 8'h00;
        model_reset();

        // Reset and post-reset status
        cycle(1'b1, 1'b0, 1'b1, '0, 8'h00);
        cycle(1'b1, 1'b0, 1'b1, '0, 8'h00);
        rd(2'd1);
        rd(2'd3);
        rd(2'd0);

        // Single frame on ch0
        wr(2'd0, 8'h55);
        idle(50);

        // Back-to-back frames on ch1
        wr(2'd2, 8'hA1);
        wr(2'd2, 8'hB2);
        for (int i = 0; i < 90; i++) rd(2'd3);

        // Overflow on ch0, then clear OVR
        for (int i = 0; i < 5; i++) wr(2'd0, 8'h10 + 8'(i));
        rd(2'd1);
        wr(2'd1, 8'h08);
        rd(2'd1);
        idle(220);

        // IRQ enable on ch1 and a frame through it
        wr(2'd3, 8'h04);
        idle(3);
        wr(2'd2, 8'h3C);
        for (int i = 0; i < 50; i++) rd(2'd3);
        wr(2'd3, 8'h00);

        // Reset mid-frame on ch0
        wr(2'd0, 8'hC3);
        idle(18);
        cycle(1'b1, 1'b0, 1'b1, '0, 8'h00);
        rd(2'd1);
        idle(10);

        // Randomised traffic at several write densities
        for (int seg = 0; seg < 10; seg++) begin
            case (seg % 3)
                0:       wr_pct = 30;
                1:       wr_pct = 5;
                default: wr_pct = 1;
            endcase
            for (int i = 0; i < 250; i++) begin
                r_rs = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 999) == 0)
                    cycle(1'b1, 1'b0, 1'b1, '0, 8'h00);
                else if (int'($urandom_range(0, 99)) < wr_pct)
                    cycle(1'b0, 1'b1, 1'b0, r_rs, 8'($urandom));
                else
                    cycle(1'b0, 1'($urandom_range(0, 1)), 1'b1, r_rs, 8'($urandom));
            end
        end
        idle(100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
